vga_pixel_sink: RTL and testbench
=================================

// Module: vga_pixel_sink
// PURPOSE
// - Display-side end of the 10-bit RGB pixel path: generates VGA raster timing, requests pixels
//   from the colour-filter stage, registers returned RGB and drives the DAC/connector pins.
// - Sits after the per-channel colour filter; the filter outputs feed iRed/iGreen/iBlue.
// - One pixel clock domain; all pin outputs are registered.
// PARAMETERS
// H_SYNC   96   hsync pulse width, pixel clocks
// H_BACK   48   horizontal back porch
// H_ACT    640  active pixels per line
// H_FRONT  16   horizontal front porch
// V_SYNC   2    vsync pulse width, lines
// V_BACK   33   vertical back porch
// V_ACT    480  active lines per frame
// V_FRONT  10   vertical front porch
// PORTS
// iCLK          in   1   pixel clock (25.175 MHz nominal)
// iRST_N        in   1   asynchronous reset, active low
// iRed          in   10  red sample answering oRequest in the same cycle
// iGreen        in   10  green sample, same timing
// iBlue         in   10  blue sample, same timing
// oRequest      out  1   pixel wanted this cycle; source drives iRed/iGreen/iBlue combinationally
// oCurrent_X    out  11  active column of the requested pixel, 0..H_ACT-1; 0 when oRequest=0
// oCurrent_Y    out  11  active row of the requested pixel, 0..V_ACT-1; 0 when oRequest=0
// oFrame_start  out  1   one-cycle pulse when h_cnt=0 and v_cnt=0
// oVGA_R/G/B    out  8   each channel; colour to DAC
// oVGA_HS       out  1   hsync, active low
// oVGA_VS       out  1   vsync, active low
// oVGA_BLANK_N  out  1   high while oVGA_R/G/B carry active video
// oVGA_SYNC_N   out  1   tied 0 (no sync-on-green)
// oVGA_CLOCK    out  1   ~iCLK, DAC latch clock
// BEHAVIOUR
// - Counters h_cnt 0..H_TOT-1, v_cnt 0..V_TOT-1.
//   H_TOT = sum of H_*, V_TOT = sum of V_*; H_BLK = H_SYNC+H_BACK, V_BLK = V_SYNC+V_BACK.
// - Counter stepping:
//   - h_cnt increments every clock; at H_TOT-1 it wraps to 0 and v_cnt increments.
//   - v_cnt wraps to 0 after V_TOT-1, only on an h_cnt wrap.
// - Line order is sync, back porch, active, front porch (same order vertically).
// - req = (H_BLK <= h_cnt < H_BLK+H_ACT) && (V_BLK <= v_cnt < V_BLK+V_ACT).
// - oRequest = req, decoded from the counter registers.
//   - oCurrent_X = h_cnt-H_BLK and oCurrent_Y = v_cnt-V_BLK while req; 0 otherwise.
// - Output register stage: every pin output is updated at the edge after the counter state
//   that decides it, so the fixed latency is 1 clock.
//   - oVGA_BLANK_N <= req
//   - oVGA_HS <= ~(h_cnt < H_SYNC)
//   - oVGA_VS <= ~(v_cnt < V_SYNC)
//   - oVGA_R <= req ? iRed[9:2] : 8'h00; G and B follow the same rule.
//   - Width rule: truncate the 2 LSBs; no rounding and no saturation.
// - Sync, blank and colour therefore stay mutually aligned. Colour is forced to 0 whenever
//   BLANK_N=0, whatever the inputs are.
// - oFrame_start is combinational from the counters; it is 1 cycle ahead of the pin outputs.
// - Reset (iRST_N=0, asynchronous):
//   - h_cnt=0, v_cnt=0
//   - oVGA_R/G/B=0, oVGA_BLANK_N=0, oVGA_HS=1, oVGA_VS=1
//   - oRequest=0, oCurrent_X=0, oCurrent_Y=0
// - Reset release:
//   - The first edge is the first pixel of the sync line: oVGA_HS=0 and oVGA_VS=0 after that edge.
//   - oFrame_start is high in the first cycle.
// - Reset asserted mid-frame: everything returns to the reset values immediately; the raster
//   restarts from 0,0 and no partial-line state is retained.
// - Input values are ignored when oRequest=0.
// TESTING
// - Reset then release, defaults:
//   - oFrame_start=1 in cycle 0; HS low for 96 clks; VS low for 2 lines (1600 clks).
//   - HS period 800 clks; VS period 420000 clks.
// - First pixel:
//   - First oRequest occurs at h_cnt=144, v_cnt=35, with oCurrent_X=0 and oCurrent_Y=0.
//   - oVGA_BLANK_N rises 1 clk later.
//   - Exactly 640 requests per line, 307200 per frame.
// - Colour path:
//   - iRed=10'h3FF, iGreen=10'h200, iBlue=10'h003 during req
//     -> next cycle R=8'hFF, G=8'h80, B=8'h00.
// - Blanking: hold iRed/iGreen/iBlue=10'h3FF constantly -> R/G/B=0 whenever BLANK_N=0;
//   never nonzero outside the active window.
// - Coordinates:
//   - The last request of a frame shows oCurrent_X=639, oCurrent_Y=479.
//   - The next cycle drops oRequest, and oCurrent_X/oCurrent_Y go to 0.
// - Mid-frame reset: pulse iRST_N low 3 clks at v_cnt=200
//   -> outputs immediately take the reset values.
//   -> After release the timing matches the first test exactly.

Source files
------------

// File: rtl/vga_pixel_sink.sv
// VGA raster generator and pixel sink: requests pixels from the colour-filter stage,
// registers the returned 10-bit RGB as 8-bit DAC colour and drives aligned sync/blank pins.
module vga_pixel_sink #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_ACT   = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_ACT   = 480,
    parameter int V_FRONT = 10
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [9:0]  iRed,
    input  logic [9:0]  iGreen,
    input  logic [9:0]  iBlue,
    output logic        oRequest,
    output logic [10:0] oCurrent_X,
    output logic [10:0] oCurrent_Y,
    output logic        oFrame_start,
    output logic [7:0]  oVGA_R,
    output logic [7:0]  oVGA_G,
    output logic [7:0]  oVGA_B,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_BLANK_N,
    output logic        oVGA_SYNC_N,
    output logic        oVGA_CLOCK
);

    localparam int H_TOT = H_SYNC + H_BACK + H_ACT + H_FRONT;
    localparam int V_TOT = V_SYNC + V_BACK + V_ACT + V_FRONT;

    localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOT - 1);
    localparam logic [10:0] H_SYNC_C = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_C = 11'(V_SYNC);
    localparam logic [10:0] H_BLK_C  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] V_BLK_C  = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] H_END_C  = 11'(H_SYNC + H_BACK + H_ACT);
    localparam logic [10:0] V_END_C  = 11'(V_SYNC + V_BACK + V_ACT);

    logic [10:0] hCnt;
    logic [10:0] vCnt;
    logic        req;

    // The two colour LSBs are dropped on the way to the 8-bit DAC.
    logic unusedLsbs;
    assign unusedLsbs = ^{iRed[1:0], iGreen[1:0], iBlue[1:0]};

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (hCnt == H_LAST) begin
            hCnt <= '0;
            vCnt <= (vCnt == V_LAST) ? '0 : vCnt + 11'd1;
        end else begin
            hCnt <= hCnt + 11'd1;
        end
    end

    always_comb begin
        req = (hCnt >= H_BLK_C) && (hCnt < H_END_C) &&
              (vCnt >= V_BLK_C) && (vCnt < V_END_C);
    end

    assign oRequest     = req;
    assign oCurrent_X   = req ? hCnt - H_BLK_C : '0;
    assign oCurrent_Y   = req ? vCnt - V_BLK_C : '0;
    assign oFrame_start = (hCnt == '0) && (vCnt == '0);

    // Sync, blank and colour all register from the same counter state so they stay aligned.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oVGA_R       <= 8'h00;
            oVGA_G       <= 8'h00;
            oVGA_B       <= 8'h00;
            oVGA_BLANK_N <= 1'b0;
            oVGA_HS      <= 1'b1;
            oVGA_VS      <= 1'b1;
        end else begin
            oVGA_R       <= req ? iRed[9:2]   : 8'h00;
            oVGA_G       <= req ? iGreen[9:2] : 8'h00;
            oVGA_B       <= req ? iBlue[9:2]  : 8'h00;
            oVGA_BLANK_N <= req;
            oVGA_HS      <= ~(hCnt < H_SYNC_C);
            oVGA_VS      <= ~(vCnt < V_SYNC_C);
        end
    end

    assign oVGA_SYNC_N = 1'b0;
    assign oVGA_CLOCK  = ~iCLK;

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Bench for vga_pixel_sink: a shrunken-raster instance checked every cycle against a
// frame-position model, plus a full-size instance pinned with hand-computed timing literals.
module tb_vga_pixel_sink;

    localparam int SHS = 4;
    localparam int SHB = 3;
    localparam int SHA = 8;
    localparam int SHF = 2;
    localparam int SVS = 2;
    localparam int SVB = 2;
    localparam int SVA = 4;
    localparam int SVF = 1;
    localparam int SHT = SHS + SHB + SHA + SHF;
    localparam int SVT = SVS + SVB + SVA + SVF;
    localparam int SFT = SHT * SVT;

    logic       clk = 1'b0;
    logic       rstN;
    logic [9:0] red, green, blue;

    logic        sReq, sFs, sHs, sVs, sBlank, sSyncN, sClk;
    logic [10:0] sX, sY;
    logic [7:0]  sR, sG, sB;
    logic        dReq, dFs, dHs, dVs, dBlank, dSyncN, dClk;
    logic [10:0] dX, dY;
    logic [7:0]  dR, dG, dB;

    vga_pixel_sink #(
        .H_SYNC(SHS), .H_BACK(SHB), .H_ACT(SHA), .H_FRONT(SHF),
        .V_SYNC(SVS), .V_BACK(SVB), .V_ACT(SVA), .V_FRONT(SVF)
    ) dutS (
        .iCLK(clk), .iRST_N(rstN), .iRed(red), .iGreen(green), .iBlue(blue),
        .oRequest(sReq), .oCurrent_X(sX), .oCurrent_Y(sY), .oFrame_start(sFs),
        .oVGA_R(sR), .oVGA_G(sG), .oVGA_B(sB), .oVGA_HS(sHs), .oVGA_VS(sVs),
        .oVGA_BLANK_N(sBlank), .oVGA_SYNC_N(sSyncN), .oVGA_CLOCK(sClk)
    );

    vga_pixel_sink dutD (
        .iCLK(clk), .iRST_N(rstN), .iRed(red), .iGreen(green), .iBlue(blue),
        .oRequest(dReq), .oCurrent_X(dX), .oCurrent_Y(dY), .oFrame_start(dFs),
        .oVGA_R(dR), .oVGA_G(dG), .oVGA_B(dB), .oVGA_HS(dHs), .oVGA_VS(dVs),
        .oVGA_BLANK_N(dBlank), .oVGA_SYNC_N(dSyncN), .oVGA_CLOCK(dClk)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int mode = 0;
    bit checkOn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus();
        case (mode)
            1:       begin red = 10'h3FF; green = 10'h3FF; blue = 10'h3FF; end
            2:       begin red = 10'h3FF; green = 10'h200; blue = 10'h003; end
            default: begin
                red   = 10'($urandom);
                green = 10'($urandom);
                blue  = 10'($urandom);
            end
        endcase
    endtask

    always @(negedge clk) applyStimulus();

    // Model: k counts clock edges since reset release; frame position is k mod frame length.
    int k = 0;
    logic [7:0] eR = 8'h00, eG = 8'h00, eB = 8'h00;
    logic eBlank = 1'b0, eHs = 1'b1, eVs = 1'b1;

    function automatic bit modelReq(input int h, input int v);
        return (h >= SHS + SHB) && (h < SHS + SHB + SHA) &&
               (v >= SVS + SVB) && (v < SVS + SVB + SVA);
    endfunction

    always @(negedge rstN) begin
        k = 0;
        eR = 8'h00; eG = 8'h00; eB = 8'h00;
        eBlank = 1'b0; eHs = 1'b1; eVs = 1'b1;
    end

    always @(posedge clk) begin
        if (rstN) begin
            int pos, h, v;
            bit r;
            pos = k % SFT;
            h = pos % SHT;
            v = pos / SHT;
            r = modelReq(h, v);
            eBlank = r;
            eHs = (h >= SHS);
            eVs = (v >= SVS);
            eR = r ? red[9:2]   : 8'h00;
            eG = r ? green[9:2] : 8'h00;
            eB = r ? blue[9:2]  : 8'h00;
            k++;
        end
    end

    always @(negedge clk) begin
        if (checkOn) begin
            int pos, h, v;
            bit r;
            pos = k % SFT;
            h = pos % SHT;
            v = pos / SHT;
            r = modelReq(h, v);
            checkOutput("request", sReq, r);
            checkOutput("currentX", sX, r ? h - (SHS + SHB) : 0);
            checkOutput("currentY", sY, r ? v - (SVS + SVB) : 0);
            checkOutput("frameStart", sFs, pos == 0);
            checkOutput("vgaR", sR, eR);
            checkOutput("vgaG", sG, eG);
            checkOutput("vgaB", sB, eB);
            checkOutput("blankN", sBlank, eBlank);
            checkOutput("hsync", sHs, eHs);
            checkOutput("vsync", sVs, eVs);
            checkOutput("syncN", sSyncN, 0);
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_sHs"}, sHs, 1);
        checkOutput({tag, "_sVs"}, sVs, 1);
        checkOutput({tag, "_sBlank"}, sBlank, 0);
        checkOutput({tag, "_sRGB"}, {sR, sG, sB}, 0);
        checkOutput({tag, "_sReq"}, sReq, 0);
        checkOutput({tag, "_sXY"}, {sX, sY}, 0);
        checkOutput({tag, "_dHs"}, dHs, 1);
        checkOutput({tag, "_dVs"}, dVs, 1);
        checkOutput({tag, "_dBlank"}, dBlank, 0);
        checkOutput({tag, "_dRGB"}, {dR, dG, dB}, 0);
        checkOutput({tag, "_dReqXY"}, {dReq, dX, dY}, 0);
        checkOutput({tag, "_dSyncN"}, dSyncN, 0);
    endtask

    // Runs from just after reset release; n is the number of edges seen at each sample.
    task automatic measureTiming(input string tag);
        int sFirstReq = -1, sFirstBlank = -1, sReqXY = -1;
        int dFirstReq = -1, dFirstBlank = -1, dReqXY = -1;
        int dHsLow = 0, dVsLow = 0, dHsFalls = 0, dFirstFall = -1, dSecondFall = -1;
        logic prevHs = 1'b1;
        for (int n = 1; n <= 28200; n++) begin
            @(negedge clk);
            if (sReq && sFirstReq < 0) begin sFirstReq = n; sReqXY = int'({sX, sY}); end
            if (sBlank && sFirstBlank < 0) sFirstBlank = n;
            if (dReq && dFirstReq < 0) begin dFirstReq = n; dReqXY = int'({dX, dY}); end
            if (dBlank && dFirstBlank < 0) dFirstBlank = n;
            if (n <= 800 && !dHs) dHsLow++;
            if (n <= 2000 && !dVs) dVsLow++;
            if (prevHs && !dHs) begin
                dHsFalls++;
                if (dHsFalls == 1) dFirstFall = n;
                if (dHsFalls == 2) dSecondFall = n;
            end
            prevHs = dHs;
        end
        checkOutput({tag, "_sFirstReq"}, sFirstReq, 75);
        checkOutput({tag, "_sFirstBlank"}, sFirstBlank, 76);
        checkOutput({tag, "_sFirstXY"}, sReqXY, 0);
        checkOutput({tag, "_dFirstReq"}, dFirstReq, 28144);
        checkOutput({tag, "_dFirstBlank"}, dFirstBlank, 28145);
        checkOutput({tag, "_dFirstXY"}, dReqXY, 0);
        checkOutput({tag, "_dHsLow"}, dHsLow, 96);
        checkOutput({tag, "_dVsLow"}, dVsLow, 1600);
        checkOutput({tag, "_dHsFirstFall"}, dFirstFall, 1);
        checkOutput({tag, "_dHsPeriodEdge"}, dSecondFall, 801);
    endtask

    initial begin
        int found, bad, count;
        rstN = 1'b1;
        red = '0; green = '0; blue = '0;
        #2 rstN = 1'b0;
        #1 checkOn = 1'b1;
        checkResetValues("reset");
        @(posedge clk); #1 checkOutput("dacClockHigh", {sClk, dClk}, 2'b00);
        @(negedge clk); #1 checkOutput("dacClockLow", {sClk, dClk}, 2'b11);
        repeat (2) @(negedge clk);
        #1 rstN = 1'b1;
        checkOutput("sFrameStartCycle0", sFs, 1);
        checkOutput("dFrameStartCycle0", dFs, 1);
        measureTiming("first");

        mode = 1;
        repeat (2) @(negedge clk);
        bad = 0;
        count = 0;
        for (int i = 0; i < 2 * SFT; i++) begin
            @(negedge clk);
            if (!sBlank && ({sR, sG, sB} != 0)) bad++;
            if (sBlank && {sR, sG, sB} == 24'hFFFFFF) count++;
        end
        checkOutput("blankForcesZero", bad, 0);
        checkOutput("activeWhiteCount", count, 2 * SHA * SVA);

        mode = 2;
        repeat (2) @(negedge clk);
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (sBlank) found = 1;
        end
        checkOutput("colourBlankFound", found, 1);
        checkOutput("colourR", sR, 8'hFF);
        checkOutput("colourG", sG, 8'h80);
        checkOutput("colourB", sB, 8'h00);
        mode = 0;

        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (sReq && sX == 11'd7 && sY == 11'd3) found = 1;
        end
        checkOutput("lastReqFound", found, 1);
        @(negedge clk);
        checkOutput("afterLastReq", {sReq, sX, sY}, 0);

        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (sFs) found = 1;
        end
        checkOutput("frameStartFound", found, 1);
        count = sReq ? 1 : 0;
        for (int i = 1; i < SFT; i++) begin
            @(negedge clk);
            if (sReq) count++;
        end
        checkOutput("requestsPerFrame", count, SHA * SVA);

        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (sReq && sY == 11'd2) found = 1;
        end
        checkOutput("midFrameFound", found, 1);
        @(negedge clk);
        #1 rstN = 1'b0;
        #1 checkResetValues("midReset");
        repeat (3) @(negedge clk);
        #1 rstN = 1'b1;
        checkOutput("sFrameStartRestart", sFs, 1);
        checkOutput("dFrameStartRestart", dFs, 1);
        measureTiming("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
